local_pht: RTL and testbench
============================

Name: local_pht

Overview:
- Local pattern history table: 1024 x 3-bit saturating counters, indexed by the 10-bit local branch history that the branch history table produces in fetch.
- Produces a registered taken/not-taken local prediction one cycle after the read request.
- Trains counters from committed branch outcomes through a 2-stage read-modify-write pipeline with forwarding.
- Self-initialises the counter array after reset with a sweep FSM, so the array needs no per-entry reset flops.

Parameters:
- INDEX_W, 10: index width; the table has 2**INDEX_W entries.
- CNT_W, 3: saturating counter width.
- PHT_INIT, 3'b011: value written to every entry during the init sweep (weakly not-taken).

Ports:
- clock  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- pht_rd_en_i  in  1  prediction lookup request.
- pht_rd_index_i  in  INDEX_W  lookup index; this is the speculative local history.
- pht_cm_update_i  in  1  committed-branch update strobe.
- pht_wt_index_i  in  INDEX_W  committed local history; the index to train.
- pht_cm_brdir_i  in  1  committed direction (1 = taken).
- pht_ready_o  out  1  init sweep complete.
- pht_pred_valid_o  out  1  prediction outputs valid this cycle.
- pht_pred_taken_o  out  1  predicted direction, equal to counter MSB.
- pht_pred_cnt_o  out  CNT_W  raw counter value, used by the choice/tournament logic.

Behaviour:
- Reset (async, reset_n low):
  - FSM to INIT, init_ptr = 0, both update-stage valids cleared.
  - All outputs 0.
  - Array contents are not reset; the sweep rewrites them.
  - Reset asserted mid-sweep or mid-update restarts the sweep from 0 and drops all in-flight updates.
- FSM state INIT:
  - Each cycle writes PHT_INIT to entry init_ptr, then init_ptr += 1.
  - After the write to entry 2**INDEX_W-1, go to READY.
  - pht_ready_o rises on the 1025th rising edge after reset_n deasserts.
  - pht_rd_en_i and pht_cm_update_i are ignored in INIT: no prediction, updates are lost.
- FSM state READY: terminal until the next reset.
- Read, READY only:
  - pht_rd_en_i in cycle N gives pht_pred_valid_o = 1 in N+1, with pht_pred_cnt_o = counter and pht_pred_taken_o = cnt[CNT_W-1].
  - Outputs are registered.
  - With pht_rd_en_i low, valid = 0; cnt/taken hold their last values.
- Update pipeline:
  - U1 (cycle N, when pht_cm_update_i && READY): register index, direction, and the old counter.
    - Old counter is the array value, or W's new value if W is valid and has the same index (back-to-back forward).
  - W (cycle N+1): compute the new counter, write it to the array at the end of N+1.
  - Saturation: taken increments, held at 2**CNT_W-1; not-taken decrements, held at 0.
  - Throughput is one update per cycle, no stalls, no backpressure.
- Read/update collision:
  - A read in the same cycle as W to the same index returns W's new value (forwarded).
  - A read in the same cycle as U1 to the same index returns the pre-update value; this is architecturally acceptable.
- Same-index updates in consecutive cycles must each apply: two taken updates from 3 give 5, never 4.
- Single write port: sweep writes (INIT) and W writes (READY) are mutually exclusive by FSM state.

Decomposition:
- Shared package (bp_pkg) holds:
  - PHT_INDEX_W and PHT_CNT_W.
  - PHT_INIT_VAL.
  - Init/ready state enum.
  - Saturating inc/dec function, also used by the choice predictor.
- One natural sub-module: pht_sat_cnt_upd, the combinational saturating update (counter, direction -> new counter), reused by the global PHT and the chooser.
- Storage array and FSM stay in local_pht.

Test Plan:
- Init timing: release reset, hold rd_en = 1 -> pht_ready_o 0 for 1024 cycles, 1 from edge 1025; pred_valid stays 0 throughout INIT; first READY read of index 0x3FF returns cnt = 3, taken = 0.
- Saturation: 5 taken updates to 0x155 spaced 3 cycles apart -> reads give 4, 5, 6, 7, 7. Then 8 not-taken -> 0, and it holds at 0.
- Back-to-back forward: consecutive-cycle updates to 0x0AA T, T, T, N from 3 -> final read 5. Interleaved index 0x0AB T gives 4 there and does not disturb 0x0AA.
- Read/W bypass: update 0x200 T in cycle N, read 0x200 in N+1 -> cnt = 4 (forwarded) in N+2. Read 0x200 in cycle N -> cnt = 3.
- Updates during INIT: pulse pht_cm_update_i T to 0x010 at cycle 500 of the sweep -> after ready, read 0x010 returns 3.
- Reset mid-operation: assert reset_n low at sweep cycle 700, release -> ready again exactly 1024 cycles later. Reset with an update in W -> the update is discarded and the entry reads 3 after re-init.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: table geometry, init value, init/ready
// state encoding and the saturating counter step used by all counter tables.
package bp_pkg;

    localparam int PHT_INDEX_W = 10;
    localparam int PHT_CNT_W   = 3;
    localparam logic [PHT_CNT_W-1:0] PHT_INIT_VAL = 3'b011;

    typedef enum logic {
        PHT_ST_INIT  = 1'b0,
        PHT_ST_READY = 1'b1
    } pht_state_e;

    // Width-agnostic step so tables with different counter widths can share it.
    function automatic logic [7:0] sat_cnt_step(input logic [7:0] cnt,
                                                input logic [7:0] cnt_max,
                                                input logic       taken);
        logic [7:0] result;
        result = cnt;
        if (taken) begin
            if (cnt < cnt_max) result = cnt + 8'd1;
        end else begin
            if (cnt != 8'd0) result = cnt - 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pht_sat_cnt_upd.sv
// Combinational saturating counter update: taken counts up, not-taken counts
// down, both clamped at the counter's range limits.
module pht_sat_cnt_upd
    import bp_pkg::*;
#(
    parameter int CNT_W = PHT_CNT_W
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [7:0] CNT_MAX = 8'((1 << CNT_W) - 1);

    assign cnt_next = CNT_W'(sat_cnt_step(8'(cnt), CNT_MAX, taken));

endmodule

// File: rtl/local_pht.sv
// Local pattern history table: registered lookups, a two-stage read-modify-write
// training pipeline with forwarding, and a post-reset sweep that seeds every entry.
module local_pht
    import bp_pkg::*;
#(
    parameter int               INDEX_W  = PHT_INDEX_W,
    parameter int               CNT_W    = PHT_CNT_W,
    parameter logic [CNT_W-1:0] PHT_INIT = CNT_W'(PHT_INIT_VAL)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pht_rd_en_i,
    input  logic [INDEX_W-1:0] pht_rd_index_i,
    input  logic               pht_cm_update_i,
    input  logic [INDEX_W-1:0] pht_wt_index_i,
    input  logic               pht_cm_brdir_i,
    output logic               pht_ready_o,
    output logic               pht_pred_valid_o,
    output logic               pht_pred_taken_o,
    output logic [CNT_W-1:0]   pht_pred_cnt_o
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [CNT_W-1:0]   pht_mem [DEPTH];

    pht_state_e         state, state_next;
    logic [INDEX_W-1:0] init_ptr, init_ptr_next;

    logic               w_valid;
    logic               w_dir;
    logic [INDEX_W-1:0] w_idx;
    logic [CNT_W-1:0]   w_old;
    logic [CNT_W-1:0]   w_new;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    logic [CNT_W-1:0]   wr_data;

    logic               is_ready;
    logic               u1_fire;
    logic               rd_fire;
    logic [CNT_W-1:0]   u1_old;
    logic [CNT_W-1:0]   rd_cnt;

    assign is_ready = (state == PHT_ST_READY);
    assign u1_fire  = pht_cm_update_i && is_ready;
    assign rd_fire  = pht_rd_en_i && is_ready;

    pht_sat_cnt_upd #(.CNT_W(CNT_W)) u_sat_upd (
        .cnt      (w_old),
        .taken    (w_dir),
        .cnt_next (w_new)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PHT_ST_INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_next;
            init_ptr <= init_ptr_next;
        end
    end

    // The single write port belongs to the sweep in INIT and to stage W in READY.
    always_comb begin
        state_next    = state;
        init_ptr_next = init_ptr;
        wr_en         = 1'b0;
        wr_idx        = w_idx;
        wr_data       = w_new;
        case (state)
            PHT_ST_INIT: begin
                wr_en         = 1'b1;
                wr_idx        = init_ptr;
                wr_data       = PHT_INIT;
                init_ptr_next = init_ptr + 1'b1;
                if (init_ptr == '1) state_next = PHT_ST_READY;
            end
            PHT_ST_READY: begin
                wr_en = w_valid;
            end
            default: state_next = PHT_ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) pht_mem[wr_idx] <= wr_data;
    end

    // Forward W's result so back-to-back updates and reads see the newest count.
    always_comb begin
        u1_old = pht_mem[pht_wt_index_i];
        rd_cnt = pht_mem[pht_rd_index_i];
        if (w_valid && (w_idx == pht_wt_index_i)) u1_old = w_new;
        if (w_valid && (w_idx == pht_rd_index_i)) rd_cnt = w_new;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_valid <= 1'b0;
            w_dir   <= 1'b0;
            w_idx   <= '0;
            w_old   <= '0;
        end else begin
            w_valid <= u1_fire;
            if (u1_fire) begin
                w_dir <= pht_cm_brdir_i;
                w_idx <= pht_wt_index_i;
                w_old <= u1_old;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pht_ready_o      <= 1'b0;
            pht_pred_valid_o <= 1'b0;
            pht_pred_taken_o <= 1'b0;
            pht_pred_cnt_o   <= '0;
        end else begin
            pht_ready_o      <= is_ready;
            pht_pred_valid_o <= rd_fire;
            if (rd_fire) begin
                pht_pred_cnt_o   <= rd_cnt;
                pht_pred_taken_o <= rd_cnt[CNT_W-1];
            end
        end
    end

endmodule

// File: tb/tb_local_pht.sv
// Self-checking bench for local_pht: directed scenarios plus a randomized phase,
// all compared against an architectural model of the counter table.
module tb_local_pht;

    localparam int INDEX_W = 10;
    localparam int CNT_W   = 3;
    localparam int DEPTH   = 1 << INDEX_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int INIT_V  = 3;

    logic               clock;
    logic               reset_n;
    logic               pht_rd_en_i;
    logic [INDEX_W-1:0] pht_rd_index_i;
    logic               pht_cm_update_i;
    logic [INDEX_W-1:0] pht_wt_index_i;
    logic               pht_cm_brdir_i;
    logic               pht_ready_o;
    logic               pht_pred_valid_o;
    logic               pht_pred_taken_o;
    logic [CNT_W-1:0]   pht_pred_cnt_o;

    int n_checks;
    int n_fail;
    int edges;
    int model_cnt [DEPTH];
    int last_cnt;

    local_pht dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pht_rd_en_i      (pht_rd_en_i),
        .pht_rd_index_i   (pht_rd_index_i),
        .pht_cm_update_i  (pht_cm_update_i),
        .pht_wt_index_i   (pht_wt_index_i),
        .pht_cm_brdir_i   (pht_cm_brdir_i),
        .pht_ready_o      (pht_ready_o),
        .pht_pred_valid_o (pht_pred_valid_o),
        .pht_pred_taken_o (pht_pred_taken_o),
        .pht_pred_cnt_o   (pht_pred_cnt_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: actual=%0d required=%0d", tag, edges, actual, expected);
        end
    endtask

    // Architectural rule: every accepted update applies in order; a read sees all
    // updates accepted in earlier cycles but not one accepted in its own cycle.
    task automatic applyStimulus(input logic rd_en, input int rd_idx,
                                 input logic upd, input int wt_idx, input logic dir);
        logic accepting;
        logic exp_valid;
        int   exp_cnt;
        pht_rd_en_i     = rd_en;
        pht_rd_index_i  = rd_idx[INDEX_W-1:0];
        pht_cm_update_i = upd;
        pht_wt_index_i  = wt_idx[INDEX_W-1:0];
        pht_cm_brdir_i  = dir;
        accepting = (edges >= DEPTH);
        exp_valid = rd_en && accepting;
        exp_cnt   = model_cnt[rd_idx];
        if (upd && accepting) begin
            if (dir) model_cnt[wt_idx] = (model_cnt[wt_idx] == CNT_MAX) ? CNT_MAX : model_cnt[wt_idx] + 1;
            else     model_cnt[wt_idx] = (model_cnt[wt_idx] == 0) ? 0 : model_cnt[wt_idx] - 1;
        end
        @(posedge clock);
        #1;
        edges++;
        if (exp_valid) last_cnt = exp_cnt;
        checkOutput("ready", int'(pht_ready_o), int'(edges >= DEPTH + 1));
        checkOutput("pred_valid", int'(pht_pred_valid_o), int'(exp_valid));
        checkOutput("pred_cnt", int'(pht_pred_cnt_o), last_cnt);
        checkOutput("pred_taken", int'(pht_pred_taken_o), int'(last_cnt >= (CNT_MAX + 1) / 2));
    endtask

    task automatic doReset();
        reset_n         = 1'b0;
        pht_rd_en_i     = 1'b0;
        pht_rd_index_i  = '0;
        pht_cm_update_i = 1'b0;
        pht_wt_index_i  = '0;
        pht_cm_brdir_i  = 1'b0;
        #1;
        checkOutput("reset_ready", int'(pht_ready_o), 0);
        checkOutput("reset_valid", int'(pht_pred_valid_o), 0);
        checkOutput("reset_cnt", int'(pht_pred_cnt_o), 0);
        checkOutput("reset_taken", int'(pht_pred_taken_o), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        edges    = 0;
        last_cnt = 0;
        for (int i = 0; i < DEPTH; i++) model_cnt[i] = INIT_V;
    endtask

    task automatic readIdx(input int idx);
        applyStimulus(1'b1, idx, 1'b0, 0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edges    = 0;
        last_cnt = 0;
        $display("[TB] local_pht bench start");

        // Init sweep timing, with an update pulsed mid-sweep that must be lost.
        doReset();
        for (int c = 0; c < DEPTH + 6; c++) begin
            if (edges == 500) applyStimulus(1'b1, 'h3FF, 1'b1, 'h010, 1'b1);
            else              applyStimulus(1'b1, 'h3FF, 1'b0, 0, 1'b0);
        end
        readIdx('h010);
        idle();
        checkOutput("init_update_lost", int'(pht_pred_cnt_o), INIT_V);

        // Saturation up then down, updates spaced three cycles apart.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 0, 1'b1, 'h155, 1'b1);
            idle();
            readIdx('h155);
        end
        idle();
        checkOutput("sat_high", int'(pht_pred_cnt_o), CNT_MAX);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 0, 1'b1, 'h155, 1'b0);
            idle();
            readIdx('h155);
        end
        idle();
        checkOutput("sat_low", int'(pht_pred_cnt_o), 0);

        // Back-to-back same-index updates, then an interleaved neighbour.
        applyStimulus(1'b0, 0, 1'b1, 'h0AA, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 'h0AA, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 'h0AA, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 'h0AA, 1'b0);
        readIdx('h0AA);
        idle();
        checkOutput("b2b_final", int'(pht_pred_cnt_o), 5);
        applyStimulus(1'b0, 0, 1'b1, 'h0AB, 1'b1);
        applyStimulus(1'b1, 'h0AA, 1'b0, 0, 1'b0);
        readIdx('h0AB);
        idle();
        checkOutput("neighbour", int'(pht_pred_cnt_o), 4);

        // Read in U1's cycle sees the old value, read in W's cycle is forwarded.
        applyStimulus(1'b1, 'h200, 1'b1, 'h200, 1'b1);
        checkOutput("bypass_u1", int'(pht_pred_cnt_o), 3);
        readIdx('h200);
        checkOutput("bypass_w", int'(pht_pred_cnt_o), 4);

        // Randomized traffic on a small index window to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range('h0A0, 'h0A3)),
                          1'($urandom_range(0, 1)), int'($urandom_range('h0A0, 'h0A3)),
                          1'($urandom_range(0, 1)));
        end

        // Reset while an update sits in W: it must be discarded.
        applyStimulus(1'b0, 0, 1'b1, 'h300, 1'b1);
        doReset();
        for (int c = 0; c < 700; c++) applyStimulus(1'b1, 'h300, 1'b1, 'h300, 1'b1);

        // Reset again mid-sweep; ready must return a full sweep later.
        doReset();
        for (int c = 0; c < DEPTH + 2; c++) applyStimulus(1'b1, 'h300, 1'b0, 0, 1'b0);
        readIdx('h300);
        idle();
        checkOutput("reset_discard", int'(pht_pred_cnt_o), INIT_V);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
